// File: rtl/reset_input_conditioner_if.sv
// ---------------------------------------------------------------------------
// reset_input_conditioner_if
//   Bundles the raw DIO control pins, the conditioner controls and the
//   conditioned outputs that travel between the pin side and the reset
//   manager. Clock and reset are kept as plain ports on the module.
//
//   Signals
//     trigger_raw, watchdog_raw, instant_reset_raw : raw asynchronous pins
//     filter_en  : 1 = glitch filter active, 0 = bypassed
//     wd_en      : watchdog monitor enable
//     wd_clear   : one-cycle pulse clearing an expired watchdog
//     trigger_clean, watchdog_clean, instant_reset_clean : filtered levels
//     trigger_rise, trigger_fall : 1-cycle pulses on trigger_clean edges
//     wd_timeout : high while the monitor is expired
//     sts        : {3'b0, state[1:0], instant, watchdog, trigger}
//
//   Modports
//     master : pin/control side (drives raws and controls)
//     slave  : the conditioner itself
// ---------------------------------------------------------------------------
interface reset_input_conditioner_if;
  logic       trigger_raw;
  logic       watchdog_raw;
  logic       instant_reset_raw;
  logic       filter_en;
  logic       wd_en;
  logic       wd_clear;
  logic       trigger_clean;
  logic       trigger_rise;
  logic       trigger_fall;
  logic       watchdog_clean;
  logic       instant_reset_clean;
  logic       wd_timeout;
  logic [7:0] sts;

  modport master (
    output trigger_raw, watchdog_raw, instant_reset_raw,
    output filter_en, wd_en, wd_clear,
    input  trigger_clean, trigger_rise, trigger_fall,
    input  watchdog_clean, instant_reset_clean, wd_timeout, sts
  );

  modport slave (
    input  trigger_raw, watchdog_raw, instant_reset_raw,
    input  filter_en, wd_en, wd_clear,
    output trigger_clean, trigger_rise, trigger_fall,
    output watchdog_clean, instant_reset_clean, wd_timeout, sts
  );
endinterface

// File: rtl/reset_input_conditioner.sv
// ---------------------------------------------------------------------------
// reset_input_conditioner
//   Conditions the raw DIO control inputs (trigger, watchdog heartbeat,
//   instant reset) before they reach the reset manager. Every input runs
//   through a multi-flop synchronizer and a stability (glitch) filter; the
//   filtered trigger gets rise/fall pulses, and a small FSM watches the
//   filtered watchdog for a missing heartbeat.
//
//   Ports
//     clk                : system clock (125 MHz nominal)
//     peripheral_aresetn : asynchronous active-low reset, release is expected
//                          to be synchronous to clk
//     io (slave)         : raw pins, filter/watchdog controls, conditioned
//                          levels, trigger edge pulses, timeout and status
//
//   Parameters
//     SYNC_STAGES    : synchronizer depth (>= 2)
//     FILTER_CYCLES  : consecutive stable cycles needed to accept a level
//     TIMEOUT_CYCLES : edge-free cycles before the watchdog expires
//     CNT_W          : watchdog counter width (2**CNT_W > TIMEOUT_CYCLES)
// ---------------------------------------------------------------------------
module reset_input_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 12500000,
  parameter int CNT_W          = 24
) (
  input  logic                         clk,
  input  logic                         peripheral_aresetn,
  reset_input_conditioner_if.slave     io
);

  // Channel indices into the per-input arrays.
  localparam int NCH     = 3;
  localparam int CH_TRIG = 0;
  localparam int CH_WD   = 1;
  localparam int CH_IR   = 2;

  // A counter value of FILTER_CYCLES-1 is the last one ever needed, so the
  // filter counter only has to hold 0 .. FILTER_CYCLES-1.
  localparam int FILT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WD_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    EXPIRED = 2'd3
  } wd_state_e;

  // Saturating increment: the watchdog counter must never wrap while it
  // sits in EXPIRED, however long that lasts.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NCH-1:0]                  raw;
  logic [NCH-1:0]                  s;
  logic [NCH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [NCH-1:0][FILT_W-1:0]      fcnt_q, fcnt_d;
  logic [NCH-1:0]                  clean_q, clean_d;
  logic                            rise_q, rise_d;
  logic                            fall_q, fall_d;
  logic                            wd_edge;

  wd_state_e                       state_q;
  logic [CNT_W-1:0]                wd_cnt_q;
  logic                            wd_timeout_q;

  assign raw = {io.instant_reset_raw, io.watchdog_raw, io.trigger_raw};

  // ---- stage: synchronizer -------------------------------------------------
  always_comb begin
    sync_d = sync_q;
    for (int i = 0; i < NCH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
    end
  end

  always_comb begin
    s = '0;
    for (int i = 0; i < NCH; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // ---- stage: glitch filter and edge detection -----------------------------
  // A new level is only accepted after it has disagreed with the current
  // clean level for FILTER_CYCLES consecutive samples; any return to the
  // clean level restarts the count. With the filter bypassed the clean level
  // follows the synchronizer output one cycle later and the counter idles.
  always_comb begin
    clean_d = clean_q;
    fcnt_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!io.filter_en) begin
        clean_d[i] = s[i];
      end else if (s[i] != clean_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) begin
          clean_d[i] = s[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Pulses are computed from the upcoming clean value so they land in the
  // same cycle the new level first appears on the output.
  always_comb begin
    rise_d  =  clean_d[CH_TRIG] & ~clean_q[CH_TRIG];
    fall_d  = ~clean_d[CH_TRIG] &  clean_q[CH_TRIG];
    wd_edge =  clean_d[CH_WD]   ^  clean_q[CH_WD];
  end

  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      sync_q  <= '0;
      fcnt_q  <= '0;
      clean_q <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fcnt_q  <= fcnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // ---- stage: watchdog heartbeat monitor -----------------------------------
  // wd_edge marks the cycle in which watchdog_clean takes its new level, so
  // the counter restarts exactly when the accepted edge becomes visible and
  // expiry happens TIMEOUT_CYCLES edge-free cycles later. wd_timeout_q is
  // written alongside every state update so it always mirrors EXPIRED.
  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      state_q      <= IDLE;
      wd_cnt_q     <= '0;
      wd_timeout_q <= 1'b0;
    end else if (!io.wd_en) begin
      state_q      <= IDLE;
      wd_cnt_q     <= '0;
      wd_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q      <= ARMED;
          wd_cnt_q     <= '0;
          wd_timeout_q <= 1'b0;
        end
        ARMED: begin
          wd_cnt_q     <= '0;
          wd_timeout_q <= 1'b0;
          if (wd_edge) begin
            state_q <= RUNNING;
          end
        end
        RUNNING: begin
          // Priority at the final count: heartbeat edge, then clear, then
          // expiry.
          if (wd_edge) begin
            wd_cnt_q     <= '0;
            wd_timeout_q <= 1'b0;
          end else if (wd_cnt_q == WD_LAST) begin
            if (io.wd_clear) begin
              state_q      <= ARMED;
              wd_cnt_q     <= '0;
              wd_timeout_q <= 1'b0;
            end else begin
              state_q      <= EXPIRED;
              wd_cnt_q     <= sat_inc(wd_cnt_q);
              wd_timeout_q <= 1'b1;
            end
          end else begin
            wd_cnt_q     <= wd_cnt_q + 1'b1;
            wd_timeout_q <= 1'b0;
          end
        end
        EXPIRED: begin
          // Sticky: heartbeat edges are ignored, only a clear re-arms.
          if (io.wd_clear) begin
            state_q      <= ARMED;
            wd_cnt_q     <= '0;
            wd_timeout_q <= 1'b0;
          end else begin
            wd_cnt_q     <= sat_inc(wd_cnt_q);
            wd_timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          wd_cnt_q     <= '0;
          wd_timeout_q <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage: outputs ------------------------------------------------------
  assign io.trigger_clean       = clean_q[CH_TRIG];
  assign io.watchdog_clean      = clean_q[CH_WD];
  assign io.instant_reset_clean = clean_q[CH_IR];
  assign io.trigger_rise        = rise_q;
  assign io.trigger_fall        = fall_q;
  assign io.wd_timeout          = wd_timeout_q;
  assign io.sts                 = {3'b000, state_q, clean_q[CH_IR], clean_q[CH_WD], clean_q[CH_TRIG]};

endmodule

// File: tb/tb_reset_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_reset_input_conditioner
//   Directed bench for reset_input_conditioner. The watchdog timeout is
//   shortened to 200 cycles so the heartbeat scenarios stay short; filter
//   and synchronizer depths are the production values (latency 18).
// ---------------------------------------------------------------------------
module tb_reset_input_conditioner;

  localparam int LAT = 18;   // SYNC_STAGES + FILTER_CYCLES
  localparam int TO  = 200;  // TIMEOUT_CYCLES used here

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  reset_input_conditioner_if ifc ();

  reset_input_conditioner #(
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (16),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (8)
  ) dut (
    .clk               (clk),
    .peripheral_aresetn(rst_n),
    .io                (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    ifc.trigger_raw       = 1'b0;
    ifc.watchdog_raw      = 1'b0;
    ifc.instant_reset_raw = 1'b0;
    ifc.filter_en         = 1'b1;
    ifc.wd_en             = 1'b0;
    ifc.wd_clear          = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_assert++; if (ifc.sts !== 8'h00) begin n_fail++; $display("FAIL reset_sts got=%h exp=00", ifc.sts); end
    n_assert++; if (ifc.trigger_clean !== 1'b0) begin n_fail++; $display("FAIL reset_trig got=%b exp=0", ifc.trigger_clean); end
    n_assert++; if (ifc.trigger_rise !== 1'b0 || ifc.trigger_fall !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got=%b%b exp=00", ifc.trigger_rise, ifc.trigger_fall); end
    n_assert++; if (ifc.wd_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", ifc.wd_timeout); end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    n_assert++; if (ifc.sts !== 8'h00) begin n_fail++; $display("FAIL idle_sts got=%h exp=00", ifc.sts); end
    n_assert++; if (ifc.watchdog_clean !== 1'b0 || ifc.instant_reset_clean !== 1'b0) begin n_fail++; $display("FAIL idle_clean got=%b%b exp=00", ifc.watchdog_clean, ifc.instant_reset_clean); end
  endtask

  // T1: filtered latency and single-cycle pulses, both directions.
  task automatic test_filter_latency();
    ifc.trigger_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_assert++; if (ifc.trigger_clean !== (k >= LAT)) begin n_fail++; $display("FAIL t1_clean k=%0d got=%b exp=%b", k, ifc.trigger_clean, (k >= LAT)); end
      n_assert++; if (ifc.trigger_rise !== (k == LAT)) begin n_fail++; $display("FAIL t1_rise k=%0d got=%b exp=%b", k, ifc.trigger_rise, (k == LAT)); end
      n_assert++; if (ifc.trigger_fall !== 1'b0) begin n_fail++; $display("FAIL t1_fall k=%0d got=%b exp=0", k, ifc.trigger_fall); end
    end
    ifc.trigger_raw = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_assert++; if (ifc.trigger_clean !== (k < LAT)) begin n_fail++; $display("FAIL t1_clean_dn k=%0d got=%b exp=%b", k, ifc.trigger_clean, (k < LAT)); end
      n_assert++; if (ifc.trigger_fall !== (k == LAT)) begin n_fail++; $display("FAIL t1_fall_dn k=%0d got=%b exp=%b", k, ifc.trigger_fall, (k == LAT)); end
      n_assert++; if (ifc.trigger_rise !== 1'b0) begin n_fail++; $display("FAIL t1_rise_dn k=%0d got=%b exp=0", k, ifc.trigger_rise); end
    end
  endtask

  // T2: a 15-cycle pulse is dropped, a 16-cycle pulse passes.
  task automatic test_glitch();
    for (int len = 15; len <= 16; len++) begin
      bit acc;
      acc = (len >= 16);
      ifc.trigger_raw = 1'b1;
      for (int k = 1; k <= 40; k++) begin
        step();
        n_assert++; if (ifc.trigger_clean !== (acc && k >= LAT && k < LAT + len)) begin n_fail++; $display("FAIL t2_clean len=%0d k=%0d got=%b", len, k, ifc.trigger_clean); end
        n_assert++; if (ifc.trigger_rise !== (acc && k == LAT)) begin n_fail++; $display("FAIL t2_rise len=%0d k=%0d got=%b", len, k, ifc.trigger_rise); end
        n_assert++; if (ifc.trigger_fall !== (acc && k == LAT + len)) begin n_fail++; $display("FAIL t2_fall len=%0d k=%0d got=%b", len, k, ifc.trigger_fall); end
        if (k == len) ifc.trigger_raw = 1'b0;
      end
    end
  endtask

  // T3: filter bypassed, watchdog toggling every cycle, 3-cycle latency.
  task automatic test_bypass();
    logic hist [0:23];
    ifc.filter_en = 1'b0;
    for (int j = 0; j < 24; j++) begin
      if (j >= 3) begin
        n_assert++; if (ifc.watchdog_clean !== hist[j-3]) begin n_fail++; $display("FAIL t3_follow j=%0d got=%b exp=%b", j, ifc.watchdog_clean, hist[j-3]); end
      end
      hist[j] = (j % 2 == 1);
      ifc.watchdog_raw = hist[j];
      step();
    end
    ifc.watchdog_raw = 1'b0;
    repeat (5) step();
    n_assert++; if (ifc.watchdog_clean !== 1'b0) begin n_fail++; $display("FAIL t3_settle got=%b exp=0", ifc.watchdog_clean); end
    ifc.filter_en = 1'b1;
    repeat (5) step();
  endtask

  // T4: regular heartbeat keeps the monitor quiet; silence expires it.
  task automatic test_watchdog_timeout();
    ifc.wd_en = 1'b1;
    step();
    n_assert++; if (ifc.sts[4:3] !== 2'd1) begin n_fail++; $display("FAIL t4_armed got=%0d exp=1", ifc.sts[4:3]); end
    for (int t = 0; t < 4; t++) begin
      ifc.watchdog_raw = ~ifc.watchdog_raw;
      for (int k = 1; k <= 40; k++) begin
        step();
        n_assert++; if (ifc.wd_timeout !== 1'b0) begin n_fail++; $display("FAIL t4_quiet t=%0d k=%0d got=%b exp=0", t, k, ifc.wd_timeout); end
      end
      n_assert++; if (ifc.sts[4:3] !== 2'd2) begin n_fail++; $display("FAIL t4_running t=%0d got=%0d exp=2", t, ifc.sts[4:3]); end
    end
    ifc.watchdog_raw = ~ifc.watchdog_raw;
    for (int k = 1; k <= LAT + TO + 2; k++) begin
      step();
      n_assert++; if (ifc.wd_timeout !== (k >= LAT + TO)) begin n_fail++; $display("FAIL t4_expire k=%0d got=%b exp=%b", k, ifc.wd_timeout, (k >= LAT + TO)); end
    end
    n_assert++; if (ifc.sts[4:3] !== 2'd3) begin n_fail++; $display("FAIL t4_expired_state got=%0d exp=3", ifc.sts[4:3]); end
  endtask

  // T5: expired is sticky against heartbeats; wd_clear re-arms.
  task automatic test_expired_clear();
    for (int t = 0; t < 3; t++) begin
      ifc.watchdog_raw = ~ifc.watchdog_raw;
      for (int k = 1; k <= 40; k++) begin
        step();
        n_assert++; if (ifc.wd_timeout !== 1'b1) begin n_fail++; $display("FAIL t5_sticky t=%0d k=%0d got=%b exp=1", t, k, ifc.wd_timeout); end
      end
    end
    ifc.wd_clear = 1'b1;
    step();
    ifc.wd_clear = 1'b0;
    n_assert++; if (ifc.wd_timeout !== 1'b0) begin n_fail++; $display("FAIL t5_clear_to got=%b exp=0", ifc.wd_timeout); end
    n_assert++; if (ifc.sts[4:3] !== 2'd1) begin n_fail++; $display("FAIL t5_clear_state got=%0d exp=1", ifc.sts[4:3]); end
    step();
    n_assert++; if (ifc.sts[4:3] !== 2'd1) begin n_fail++; $display("FAIL t5_armed_hold got=%0d exp=1", ifc.sts[4:3]); end
  endtask

  // Edge arriving exactly on the final count keeps the monitor running.
  task automatic test_edge_vs_timeout();
    ifc.watchdog_raw = ~ifc.watchdog_raw;
    for (int k = 1; k <= 2 * TO + LAT + 2; k++) begin
      step();
      n_assert++; if (ifc.wd_timeout !== (k >= 2 * TO + LAT)) begin n_fail++; $display("FAIL race_edge_to k=%0d got=%b exp=%b", k, ifc.wd_timeout, (k >= 2 * TO + LAT)); end
      if (k == LAT || k == LAT + TO) begin
        n_assert++; if (ifc.sts[4:3] !== 2'd2) begin n_fail++; $display("FAIL race_edge_state k=%0d got=%0d exp=2", k, ifc.sts[4:3]); end
      end
      if (k == TO) ifc.watchdog_raw = ~ifc.watchdog_raw;
    end
  endtask

  // Clear arriving on the final count beats the timeout.
  task automatic test_clear_vs_timeout();
    ifc.wd_clear = 1'b1;
    step();
    ifc.wd_clear = 1'b0;
    ifc.watchdog_raw = ~ifc.watchdog_raw;
    for (int k = 1; k <= LAT + TO + 12; k++) begin
      step();
      n_assert++; if (ifc.wd_timeout !== 1'b0) begin n_fail++; $display("FAIL race_clr_to k=%0d got=%b exp=0", k, ifc.wd_timeout); end
      if (k == LAT + TO) begin
        n_assert++; if (ifc.sts[4:3] !== 2'd1) begin n_fail++; $display("FAIL race_clr_state got=%0d exp=1", ifc.sts[4:3]); end
      end
      if (k == LAT + TO - 1) ifc.wd_clear = 1'b1;
      if (k == LAT + TO) ifc.wd_clear = 1'b0;
    end
  endtask

  // T6: asynchronous reset mid-filter and mid-RUNNING, then full relatency.
  task automatic test_reset_midop();
    ifc.watchdog_raw = ~ifc.watchdog_raw;
    repeat (LAT + 30) step();
    n_assert++; if (ifc.sts[4:3] !== 2'd2) begin n_fail++; $display("FAIL t6_pre_running got=%0d exp=2", ifc.sts[4:3]); end
    ifc.trigger_raw       = 1'b1;
    ifc.instant_reset_raw = 1'b1;
    repeat (20) step();
    n_assert++; if (ifc.trigger_clean !== 1'b1 || ifc.instant_reset_clean !== 1'b1) begin n_fail++; $display("FAIL t6_pre_clean got=%b%b exp=11", ifc.trigger_clean, ifc.instant_reset_clean); end
    ifc.trigger_raw = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    n_assert++; if (ifc.sts !== 8'h00) begin n_fail++; $display("FAIL t6_async_sts got=%h exp=00", ifc.sts); end
    n_assert++; if (ifc.trigger_clean !== 1'b0 || ifc.instant_reset_clean !== 1'b0 || ifc.watchdog_clean !== 1'b0) begin n_fail++; $display("FAIL t6_async_clean got=%b%b%b exp=000", ifc.trigger_clean, ifc.watchdog_clean, ifc.instant_reset_clean); end
    n_assert++; if (ifc.trigger_rise !== 1'b0 || ifc.trigger_fall !== 1'b0 || ifc.wd_timeout !== 1'b0) begin n_fail++; $display("FAIL t6_async_pulses got=%b%b%b exp=000", ifc.trigger_rise, ifc.trigger_fall, ifc.wd_timeout); end
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    n_assert++; if (ifc.sts !== 8'h00) begin n_fail++; $display("FAIL t6_release_sts got=%h exp=00", ifc.sts); end
    for (int k = 1; k <= 20; k++) begin
      step();
      n_assert++; if (ifc.instant_reset_clean !== (k >= LAT)) begin n_fail++; $display("FAIL t6_relat k=%0d got=%b exp=%b", k, ifc.instant_reset_clean, (k >= LAT)); end
      n_assert++; if (ifc.trigger_clean !== 1'b0 || ifc.trigger_rise !== 1'b0 || ifc.trigger_fall !== 1'b0) begin n_fail++; $display("FAIL t6_trig k=%0d got=%b%b%b exp=000", k, ifc.trigger_clean, ifc.trigger_rise, ifc.trigger_fall); end
      if (k == 1) begin
        n_assert++; if (ifc.sts[4:3] !== 2'd1) begin n_fail++; $display("FAIL t6_rearm got=%0d exp=1", ifc.sts[4:3]); end
      end
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    test_reset();
    test_filter_latency();
    test_glitch();
    test_bypass();
    test_watchdog_timeout();
    test_expired_clear();
    test_edge_vs_timeout();
    test_clear_vs_timeout();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
